bus_valid_ready_burst_tx: RTL and testbench

Valid/ready transmitter (source end) for the team's valid/ready streaming bus. Accepts a burst command (start value, beat count) on a command handshake, then drives an incrementing data burst onto the downstream valid/ready interface with a last-beat marker. Fully registered outputs. It sits upstream of the bus pipeline register slices as a traffic/DMA-style source.

---
 rtl/bus_vr_pkg.sv | 16 +
 rtl/bus_vr_sat_cnt.sv | 29 ++
 rtl/bus_valid_ready_burst_tx.sv | 135 +++++++++++++
 tb/tb_bus_valid_ready_burst_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_vr_pkg.sv
// Shared types and defaults for the valid/ready streaming bus blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_vr_pkg;

    // Default widths shared by the slice, tx and rx ends of the bus
    localparam int BUS_VR_WIDTH = 32;
    localparam int BUS_VR_LEN_W = 8;

    // Burst source state: waiting for a command, or streaming beats
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } bus_vr_state_t;

endpackage

// File: rtl/bus_vr_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency: count updates on the edge after clr/inc.
// Backpressure: none; holds at all-ones once saturated.
module bus_vr_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Clear on request, otherwise count up and stick at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/bus_valid_ready_burst_tx.sv
// Burst source: takes (start, len) command, emits len+1 incrementing beats with last marker.
// Latency: first beat valid 1 cycle after command handshake; done pulse 1 cycle after last beat.
// Backpressure: beats held stable while ready_i low; one bubble cycle between bursts.
// Optional stall counter enabled by defining BUS_VR_BURST_TX_STALL_CNT_EN.
module bus_valid_ready_burst_tx
    import bus_vr_pkg::*;
#(
    parameter int WIDTH   = BUS_VR_WIDTH,
    parameter int LEN_W   = BUS_VR_LEN_W,
    parameter int STEP    = 1,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [WIDTH-1:0]   cmd_start_i,
    input  logic [LEN_W-1:0]   cmd_len_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH-1:0]   data_o,
    output logic               last_o,
    output logic               done_o,
    output logic [STALL_W-1:0] stall_cnt_o
);

    bus_vr_state_t    r_state;
    bus_vr_state_t    w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic [LEN_W-1:0] r_remaining;
    logic [LEN_W-1:0] w_remaining_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_cmd_acc;
    logic             w_beat_hs;

    // Command ready is a pure state decode so there is no input-to-output path
    assign cmd_ready_o = (r_state == IDLE);
    assign w_cmd_acc   = cmd_valid_i && cmd_ready_o;
    assign w_beat_hs   = r_valid && ready_i;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode; everything holds unless a handshake moves it
    always_comb begin
        w_state_nxt     = r_state;
        w_data_nxt      = r_data;
        w_remaining_nxt = r_remaining;
        w_valid_nxt     = r_valid;
        w_last_nxt      = r_last;
        w_done_nxt      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_cmd_acc) begin
                    w_data_nxt      = cmd_start_i;
                    w_remaining_nxt = cmd_len_i;
                    w_valid_nxt     = 1'b1;
                    w_last_nxt      = (cmd_len_i == '0);
                    w_state_nxt     = SEND;
                end
            end
            SEND: begin
                if (w_beat_hs) begin
                    if (!r_last) begin
                        // remaining only decrements on non-final beats, so it bottoms out at 0
                        w_data_nxt      = r_data + WIDTH'(STEP);
                        w_remaining_nxt = r_remaining - LEN_W'(1);
                        w_last_nxt      = (r_remaining == LEN_W'(1));
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_remaining <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_data      <= w_data_nxt;
            r_remaining <= w_remaining_nxt;
            r_valid     <= w_valid_nxt;
            r_last      <= w_last_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign last_o  = r_last;
    assign done_o  = r_done;

`ifdef BUS_VR_BURST_TX_STALL_CNT_EN
    logic w_stall;
    assign w_stall = r_valid && !ready_i;

    // Stall cycles of the current burst; a new command restarts the count
    bus_vr_sat_cnt #(
        .W (STALL_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_cmd_acc),
        .i_inc (w_stall),
        .o_cnt (stall_cnt_o)
    );
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bus_valid_ready_burst_tx.sv
// Directed bench for bus_valid_ready_burst_tx with hand-computed expectations.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: exercised by holding ready_i low mid-burst.
module tb_bus_valid_ready_burst_tx;

    localparam int WIDTH   = 32;
    localparam int LEN_W   = 8;
    localparam int STALL_W = 16;

    logic               clk;
    logic               rst_n;
    logic               cmd_valid_i;
    logic               cmd_ready_o;
    logic [WIDTH-1:0]   cmd_start_i;
    logic [LEN_W-1:0]   cmd_len_i;
    logic               valid_o;
    logic               ready_i;
    logic [WIDTH-1:0]   data_o;
    logic               last_o;
    logic               done_o;
    logic [STALL_W-1:0] stall_cnt_o;

    int n_vec;
    int n_err;

    bus_valid_ready_burst_tx #(
        .WIDTH   (WIDTH),
        .LEN_W   (LEN_W),
        .STEP    (1),
        .STALL_W (STALL_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_start_i (cmd_start_i),
        .cmd_len_i   (cmd_len_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .last_o      (last_o),
        .done_o      (done_o),
        .stall_cnt_o (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect a live beat on the bus
    task automatic chk_beat(input string tag, input logic [WIDTH-1:0] d, input logic l);
        chk({tag, ".valid"}, 64'(valid_o), 64'd1);
        chk({tag, ".data"},  64'(data_o),  64'(d));
        chk({tag, ".last"},  64'(last_o),  64'(l));
        chk({tag, ".done"},  64'(done_o),  64'd0);
    endtask

    // Expect the cycle right after the final handshake
    task automatic chk_done(input string tag);
        chk({tag, ".done"},  64'(done_o),      64'd1);
        chk({tag, ".valid"}, 64'(valid_o),     64'd0);
        chk({tag, ".last"},  64'(last_o),      64'd0);
        chk({tag, ".crdy"},  64'(cmd_ready_o), 64'd1);
    endtask

    // One-cycle command pulse; returns sampled just after the accepting edge
    task automatic send_cmd(input logic [WIDTH-1:0] s, input logic [LEN_W-1:0] l);
        cmd_valid_i = 1'b1;
        cmd_start_i = s;
        cmd_len_i   = l;
        step();
        cmd_valid_i = 1'b0;
    endtask

    logic [WIDTH-1:0] exp_d;
    logic [STALL_W-1:0] exp_stall;

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_start_i = '0;
        cmd_len_i   = '0;
        ready_i     = 1'b1;

        // Reset values
        #12;
        chk("rst.valid", 64'(valid_o),     64'd0);
        chk("rst.last",  64'(last_o),      64'd0);
        chk("rst.done",  64'(done_o),      64'd0);
        chk("rst.data",  64'(data_o),      64'd0);
        chk("rst.stall", 64'(stall_cnt_o), 64'd0);
        chk("rst.crdy",  64'(cmd_ready_o), 64'd1);
        #5 rst_n = 1'b1;
        step();

        // Single beat burst
        send_cmd(32'h10, 8'd0);
        chk_beat("one.b0", 32'h10, 1'b1);
        chk("one.crdy", 64'(cmd_ready_o), 64'd0);
        step();
        chk_done("one.end");
        step();
        chk("one.done_clr", 64'(done_o), 64'd0);

        // Four beats wrapping through zero
        send_cmd(32'hFFFF_FFFE, 8'd3);
        exp_d = 32'hFFFF_FFFE;
        for (int i = 0; i < 4; i++) begin
            chk_beat($sformatf("wrap.b%0d", i), exp_d, (i == 3));
            exp_d = exp_d + 32'd1;
            step();
        end
        chk_done("wrap.end");
        step();

        // Backpressure on the second beat for three cycles
        send_cmd(32'h100, 8'd3);
        chk_beat("bp.b0", 32'h100, 1'b0);
        step();
        ready_i = 1'b0;
        chk_beat("bp.b1", 32'h101, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_beat($sformatf("bp.hold%0d", i), 32'h101, 1'b0);
        end
        ready_i = 1'b1;
        step();
        chk_beat("bp.b2", 32'h102, 1'b0);
        step();
        chk_beat("bp.b3", 32'h103, 1'b1);
`ifdef BUS_VR_BURST_TX_STALL_CNT_EN
        exp_stall = 16'd3;
`else
        exp_stall = 16'd0;
`endif
        chk("bp.stall", 64'(stall_cnt_o), 64'(exp_stall));
        step();
        chk_done("bp.end");
        step();

        // Maximum length burst: 256 beats
        send_cmd(32'h0, 8'd255);
        for (int i = 0; i < 256; i++) begin
            chk_beat($sformatf("max.b%0d", i), 32'(i), (i == 255));
            step();
        end
        chk_done("max.end");
        step();
        chk("max.idle_valid", 64'(valid_o), 64'd0);

        // Back-to-back with cmd_valid held high; second command changes while busy
        cmd_valid_i = 1'b1;
        cmd_start_i = 32'h200;
        cmd_len_i   = 8'd1;
        step();
        cmd_start_i = 32'h300;
        cmd_len_i   = 8'd0;
        chk_beat("b2b.b0", 32'h200, 1'b0);
        chk("b2b.crdy0", 64'(cmd_ready_o), 64'd0);
        step();
        chk_beat("b2b.b1", 32'h201, 1'b1);
        step();
        chk_done("b2b.bubble");
        step();
        cmd_valid_i = 1'b0;
        chk_beat("b2b.c2", 32'h300, 1'b1);
        step();
        chk_done("b2b.end2");
        step();

        // Reset in the middle of a five beat burst
        send_cmd(32'h400, 8'd4);
        chk_beat("mid.b0", 32'h400, 1'b0);
        step();
        chk_beat("mid.b1", 32'h401, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.rst_valid", 64'(valid_o),     64'd0);
        chk("mid.rst_data",  64'(data_o),      64'd0);
        chk("mid.rst_last",  64'(last_o),      64'd0);
        chk("mid.rst_crdy",  64'(cmd_ready_o), 64'd1);
        step();
        chk("mid.rst_done", 64'(done_o), 64'd0);
        rst_n = 1'b1;
        step();
        chk("mid.post_done",  64'(done_o),  64'd0);
        chk("mid.post_valid", 64'(valid_o), 64'd0);
        send_cmd(32'h500, 8'd1);
        chk_beat("mid.n0", 32'h500, 1'b0);
        step();
        chk_beat("mid.n1", 32'h501, 1'b1);
        step();
        chk_done("mid.nend");
        step();
        chk("mid.final_done", 64'(done_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
